vx_mem_perf_monitor: RTL and testbench

VX_MEM_PERF_MONITOR -- requirements
Module: VX_mem_perf_monitor

---
 rtl/vx_mem_perf_monitor.sv | 155 +++++++++++++++
 tb/tb_vx_mem_perf_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_perf_monitor.sv
// Memory performance monitor: counts read/write lane fires, responses,
// outstanding reads, peak outstanding, and accumulated latency.
module vx_mem_perf_monitor #(
  parameter int NUM_CHANNELS = 1,
  parameter int NUM_LANES    = 4,
  parameter int CTR_WIDTH    = 44,
  parameter int REQ_DELAY    = 1,
  parameter int SATURATE     = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic [NUM_CHANNELS-1:0]           req_valid,
  input  logic [NUM_CHANNELS-1:0]           req_ready,
  input  logic [NUM_CHANNELS-1:0]           req_rw,
  input  logic [NUM_CHANNELS*NUM_LANES-1:0] req_mask,
  input  logic [NUM_CHANNELS-1:0]           rsp_valid,
  input  logic [NUM_CHANNELS-1:0]           rsp_ready,
  input  logic [NUM_CHANNELS*NUM_LANES-1:0] rsp_mask,
  output logic [CTR_WIDTH-1:0]              reads,
  output logic [CTR_WIDTH-1:0]              writes,
  output logic [CTR_WIDTH-1:0]              responses,
  output logic [CTR_WIDTH-1:0]              latency,
  output logic [CTR_WIDTH-1:0]              pending,
  output logic [CTR_WIDTH-1:0]              peak_pending,
  output logic                              underflow
);

  localparam int TOTAL = NUM_CHANNELS * NUM_LANES;
  localparam int CNT_W = $clog2(TOTAL + 1);
  // Two guard bits keep pending + rd_cnt - rsp_cnt exact for any operands.
  localparam int PW    = CTR_WIDTH + 2;

  logic              clr;
  logic [TOTAL-1:0]  rd_fire, wr_fire, rsp_fire;
  logic [TOTAL-1:0]  rd_dly, wr_dly;
  logic [CNT_W-1:0]  rd_cnt, wr_cnt, rsp_cnt;

  logic [CTR_WIDTH-1:0] reads_q, writes_q, responses_q, latency_q;
  logic [CTR_WIDTH-1:0] pending_q, peak_q;
  logic                 underflow_q;

  logic signed [PW-1:0] pend_sum;
  logic [CTR_WIDTH-1:0] pend_d, peak_d;
  logic                 under_evt;

  assign clr = reset | clear;

  function automatic logic [CNT_W-1:0] popcnt(input logic [TOTAL-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < TOTAL; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Wrapping or saturating counter add depending on SATURATE.
  function automatic logic [CTR_WIDTH-1:0] ctr_add(input logic [CTR_WIDTH-1:0] a,
                                                   input logic [CTR_WIDTH-1:0] b);
    logic [CTR_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if ((SATURATE != 0) && s[CTR_WIDTH]) return '1;
    return s[CTR_WIDTH-1:0];
  endfunction

  // Per-lane fire vectors from the channel handshakes and masks.
  always_comb begin
    rd_fire  = '0;
    wr_fire  = '0;
    rsp_fire = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        rd_fire[c*NUM_LANES+l]  = req_valid[c] & req_ready[c] & ~req_rw[c] & req_mask[c*NUM_LANES+l];
        wr_fire[c*NUM_LANES+l]  = req_valid[c] & req_ready[c] &  req_rw[c] & req_mask[c*NUM_LANES+l];
        rsp_fire[c*NUM_LANES+l] = rsp_valid[c] & rsp_ready[c] & rsp_mask[c*NUM_LANES+l];
      end
    end
  end

  generate
    if (REQ_DELAY == 0) begin : g_nodly
      assign rd_dly = rd_fire;
      assign wr_dly = wr_fire;
    end else begin : g_dly
      logic [TOTAL-1:0] rd_pipe_q [REQ_DELAY];
      logic [TOTAL-1:0] wr_pipe_q [REQ_DELAY];
      // Request-fire delay line; flushed by reset/clear so in-flight events are dropped.
      always_ff @(posedge clk) begin
        if (clr) begin
          for (int i = 0; i < REQ_DELAY; i++) begin
            rd_pipe_q[i] <= '0;
            wr_pipe_q[i] <= '0;
          end
        end else begin
          rd_pipe_q[0] <= rd_fire;
          wr_pipe_q[0] <= wr_fire;
          for (int i = 1; i < REQ_DELAY; i++) begin
            rd_pipe_q[i] <= rd_pipe_q[i-1];
            wr_pipe_q[i] <= wr_pipe_q[i-1];
          end
        end
      end
      assign rd_dly = rd_pipe_q[REQ_DELAY-1];
      assign wr_dly = wr_pipe_q[REQ_DELAY-1];
    end
  endgenerate

  assign rd_cnt  = popcnt(rd_dly);
  assign wr_cnt  = popcnt(wr_dly);
  assign rsp_cnt = popcnt(rsp_fire);

  // Next outstanding-read count: clamp at zero (flagging underflow), then wrap or saturate.
  always_comb begin
    under_evt = 1'b0;
    pend_sum  = $signed({2'b00, pending_q}) + $signed(PW'(rd_cnt)) - $signed(PW'(rsp_cnt));
    if (pend_sum < 0) begin
      pend_d    = '0;
      under_evt = 1'b1;
    end else if (pend_sum[PW-1:CTR_WIDTH] != 2'b00) begin
      pend_d = (SATURATE != 0) ? '1 : pend_sum[CTR_WIDTH-1:0];
    end else begin
      pend_d = pend_sum[CTR_WIDTH-1:0];
    end
    peak_d = (pend_d > peak_q) ? pend_d : peak_q;
  end

  // Counter state; reset/clear wins over every same-cycle event.
  always_ff @(posedge clk) begin
    if (clr) begin
      reads_q     <= '0;
      writes_q    <= '0;
      responses_q <= '0;
      latency_q   <= '0;
      pending_q   <= '0;
      peak_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      reads_q     <= ctr_add(reads_q, CTR_WIDTH'(rd_cnt));
      writes_q    <= ctr_add(writes_q, CTR_WIDTH'(wr_cnt));
      responses_q <= ctr_add(responses_q, CTR_WIDTH'(rsp_cnt));
      latency_q   <= ctr_add(latency_q, pending_q);
      pending_q   <= pend_d;
      peak_q      <= peak_d;
      underflow_q <= underflow_q | under_evt;
    end
  end

  assign reads        = reads_q;
  assign writes       = writes_q;
  assign responses    = responses_q;
  assign latency      = latency_q;
  assign pending      = pending_q;
  assign peak_pending = peak_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_vx_mem_perf_monitor.sv
// Directed bench for vx_mem_perf_monitor across several parameterisations.
module tb_vx_mem_perf_monitor;

  logic       clk;
  logic       reset, clear;
  logic [1:0] req_valid, req_ready, req_rw, rsp_valid, rsp_ready;
  logic [7:0] req_mask, rsp_mask;

  int checks;
  int failures;

  // A: defaults (1 channel, delay 1, 44-bit wrap)
  logic [43:0] a_rd, a_wr, a_rsp, a_lat, a_pend, a_peak;
  logic        a_uf;
  // B: 2 channels, delay 0
  logic [43:0] b_rd, b_wr, b_rsp, b_lat, b_pend, b_peak;
  logic        b_uf;
  // C: 2 channels, 4-bit saturating
  logic [3:0]  c_rd, c_wr, c_rsp, c_lat, c_pend, c_peak;
  logic        c_uf;
  // D: 2 channels, 4-bit wrapping
  logic [3:0]  d_rd, d_wr, d_rsp, d_lat, d_pend, d_peak;
  logic        d_uf;

  vx_mem_perf_monitor u_a (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid[0:0]), .req_ready(req_ready[0:0]), .req_rw(req_rw[0:0]),
    .req_mask(req_mask[3:0]), .rsp_valid(rsp_valid[0:0]), .rsp_ready(rsp_ready[0:0]),
    .rsp_mask(rsp_mask[3:0]),
    .reads(a_rd), .writes(a_wr), .responses(a_rsp), .latency(a_lat),
    .pending(a_pend), .peak_pending(a_peak), .underflow(a_uf));

  vx_mem_perf_monitor #(.NUM_CHANNELS(2), .REQ_DELAY(0)) u_b (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask),
    .reads(b_rd), .writes(b_wr), .responses(b_rsp), .latency(b_lat),
    .pending(b_pend), .peak_pending(b_peak), .underflow(b_uf));

  vx_mem_perf_monitor #(.NUM_CHANNELS(2), .CTR_WIDTH(4), .SATURATE(1)) u_c (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask),
    .reads(c_rd), .writes(c_wr), .responses(c_rsp), .latency(c_lat),
    .pending(c_pend), .peak_pending(c_peak), .underflow(c_uf));

  vx_mem_perf_monitor #(.NUM_CHANNELS(2), .CTR_WIDTH(4), .SATURATE(0)) u_d (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask),
    .reads(d_rd), .writes(d_wr), .responses(d_rsp), .latency(d_lat),
    .pending(d_pend), .peak_pending(d_peak), .underflow(d_uf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0; req_ready = '0; req_rw = '0; req_mask = '0;
    rsp_valid = '0; rsp_ready = '0; rsp_mask = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic read_ch0(input logic [3:0] m);
    req_valid = 2'b01; req_ready = 2'b01; req_rw = 2'b00; req_mask = {4'h0, m};
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear = 1'b0;
    do_reset();

    // Reset state
    check_val("rst_reads", a_rd, 0);
    check_val("rst_pending", a_pend, 0);
    check_val("rst_latency", a_lat, 0);
    check_val("rst_underflow", a_uf, 0);

    // Read mask 1011 at cycle 0: count appears after REQ_DELAY+1 cycles
    read_ch0(4'b1011);
    step();
    idle();
    check_val("dly1_early_reads", a_rd, 0);
    check_val("dly0_reads", b_rd, 3);
    step();
    check_val("mask_reads", a_rd, 3);
    check_val("mask_writes", a_wr, 0);
    check_val("mask_pending", a_pend, 3);
    check_val("mask_peak", a_peak, 3);

    // REQ_DELAY=0 latency accumulation
    do_reset();
    read_ch0(4'b0001);
    step();
    idle();
    check_val("lat_pend_c1", b_pend, 1);
    for (int i = 0; i < 4; i++) step();
    check_val("lat_pend_c5", b_pend, 1);
    rsp_valid = 2'b01; rsp_ready = 2'b01; rsp_mask = 8'h01;
    step();
    idle();
    check_val("lat_pend_c6", b_pend, 0);
    check_val("lat_latency", b_lat, 5);
    check_val("lat_responses", b_rsp, 1);

    // Same-cycle read on ch0 and write on ch1
    do_reset();
    req_valid = 2'b11; req_ready = 2'b11; req_rw = 2'b10; req_mask = 8'h3F;
    step();
    idle();
    check_val("dual_b_reads", b_rd, 4);
    check_val("dual_b_writes", b_wr, 2);
    step();
    check_val("dual_c_reads", c_rd, 4);
    check_val("dual_c_writes", c_wr, 2);

    // Read and response netted in one update
    do_reset();
    read_ch0(4'b0011);
    step();
    req_valid = 2'b10; req_ready = 2'b10; req_rw = 2'b00; req_mask = 8'h10;
    rsp_valid = 2'b01; rsp_ready = 2'b01; rsp_mask = 8'h01;
    step();
    idle();
    check_val("net_pending", b_pend, 2);
    check_val("net_reads", b_rd, 3);
    check_val("net_peak", b_peak, 2);

    // Underflow: response with nothing outstanding
    do_reset();
    rsp_valid = 2'b01; rsp_ready = 2'b01; rsp_mask = 8'h01;
    step();
    idle();
    check_val("uf_flag", a_uf, 1);
    check_val("uf_pending", a_pend, 0);
    check_val("uf_responses", a_rsp, 1);
    for (int i = 0; i < 3; i++) step();
    check_val("uf_sticky", a_uf, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("uf_cleared", a_uf, 0);
    check_val("uf_rsp_cleared", a_rsp, 0);

    // 4-bit counters: saturate vs wrap after 20 read lanes
    do_reset();
    for (int i = 0; i < 5; i++) begin
      read_ch0(4'hF);
      step();
    end
    idle();
    step();
    check_val("sat_reads", c_rd, 15);
    check_val("sat_pending", c_pend, 15);
    check_val("wrap_reads", d_rd, 4);
    check_val("wrap_pending", d_pend, 4);

    // Clear discards an event still in the delay line
    do_reset();
    read_ch0(4'b0001);
    step();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("clr_reads_c2", a_rd, 0);
    check_val("clr_pend_c2", a_pend, 0);
    step();
    step();
    check_val("clr_reads_later", a_rd, 0);
    check_val("clr_pend_later", a_pend, 0);

    // Reset mid-burst drops in-flight events
    do_reset();
    read_ch0(4'hF);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check_val("rst_burst_reads", a_rd, 0);
    check_val("rst_burst_pend", a_pend, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
